io_input_deserializer: RTL and testbench
========================================

Name: io_input_deserializer

Overview:
- Serial-to-parallel input stage directly downstream of the I_BUF input cell.
- Samples the buffered pad bit on every enabled CLK edge and assembles WIDTH-bit words, MSB-first.
- Presents each completed word with a one-cycle DATA_VALID strobe.
- Supports bitslip-driven word alignment so fabric training logic can lock onto a known pattern.

Parameters:
- WIDTH, 4, deserialization ratio (bits per output word); legal range 3..10; elaboration error outside range.
- DATA_RATE, "SDR", only "SDR" legal in this revision; elaboration error otherwise.

Ports:
- CLK  input  1  bit clock; single clock domain; all state updates on rising edge.
- RST  input  1  reset, synchronous, active-high.
- D  input  1  serial data from I_BUF O.
- EN  input  1  sample enable; low freezes all state.
- BITSLIP_ADJ  input  1  level input; each 0->1 transition requests one bit of word-boundary delay.
- Q  output  WIDTH  deserialized word; Q[WIDTH-1] = earliest-received bit.
- DATA_VALID  output  1  one-cycle strobe: Q updated this cycle.
- BITSLIP_BUSY  output  1  high while a slip request is pending, not yet consumed.

Behaviour:
- Reset (RST=1 at CLK edge): Q=0, DATA_VALID=0, BITSLIP_BUSY=0, shift register=0, bit counter=0, slip-pending=0, BITSLIP_ADJ edge-detect register=0. Partial word discarded. RST overrides EN and BITSLIP_ADJ.
- Enabled cycle (EN=1): shift register <= {shift[WIDTH-2:0], D}.
- Bit counter 0..WIDTH-1 increments on each enabled cycle, wraps WIDTH-1 -> 0.
- Word completion: enabled cycle with counter==WIDTH-1 and no slip consumed in that cycle:
  - Q <= {shift[WIDTH-2:0], D}
  - DATA_VALID <= 1
- Latency: Q/DATA_VALID visible the cycle after the last bit of the word is sampled.
- DATA_VALID is high for exactly one cycle. Q holds until the next completion.
- First enabled sample after reset is bit 0 of word 0.
- EN=0: shift register, counter, Q frozen; DATA_VALID=0; D ignored.
- Edge detect: slip-pending set on BITSLIP_ADJ 0->1, sampled every cycle regardless of EN.
- Slip consumption:
  - On the next enabled cycle with slip-pending=1, the sample shifts in but the counter holds (no increment, no completion that cycle).
  - slip-pending cleared.
  - Net effect: word boundary moves one bit later.
- Simultaneous: new 0->1 edge in the same cycle a slip is consumed re-sets pending (not lost). Further edges while already pending are merged (one slip).
- BITSLIP_BUSY = slip-pending register.
- Slip on a counter==WIDTH-1 cycle: that completion is suppressed and occurs on the following enabled cycle.
- Reset mid-word or mid-slip: everything cleared per the reset list; next word starts at the first enabled sample after RST deasserts.
- FSM (2-bit): RESET -> RUN on RST=0; RUN <-> HOLD on EN; RUN+pending -> SLIP (1 cycle) -> RUN. Any state -> RESET on RST=1.

Decomposition:
- Shared package io_cells_pkg:
  - WIDTH_MIN=3, WIDTH_MAX=10
  - state enum type for RESET/RUN/HOLD/SLIP
  - DATA_RATE string constants
- One natural sub-module: io_bitslip_ctrl (edge detect + pending flag + BITSLIP_BUSY).
- Top keeps the shift register, counter and output registers.

Test Plan (WIDTH=4):
- Reset then EN=1, D stream 1,0,1,1,0,0,1,0 -> DATA_VALID pulses the cycle after samples 4 and 8; Q=4'b1011, then 4'b0010.
- Repeating stream 1,0,0,0, Q=4'b1000 steady; one BITSLIP_ADJ pulse -> BITSLIP_BUSY high until the next enabled cycle; next valid Q=4'b0001. Three more pulses -> 4'b0010, 4'b0100, 4'b1000.
- EN=0 for 3 cycles after sample 2 of a word -> no DATA_VALID, Q unchanged; resume EN=1, two more samples -> word completes using only enabled samples.
- BITSLIP_ADJ edge while EN=0 -> BITSLIP_BUSY=1 and held; consumed on the first EN=1 cycle. Two edges before consumption -> exactly one slip.
- RST=1 at sample 3 of a word -> Q=0, DATA_VALID=0, BITSLIP_BUSY=0 next cycle; post-reset 4 samples 0,1,1,0 -> Q=4'b0110.
- Slip pending on the counter==3 cycle -> completion delayed one enabled cycle; DATA_VALID spacing 5 cycles once, then 4.

Source files
------------

// File: rtl/io_cells_pkg.sv
// Shared definitions for the I/O cell family: legal width range, FSM state type
// and data-rate names.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package io_cells_pkg;

  // Legal deserialization ratios for the input deserializer.
  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 10;

  // Data-rate names. Only SDR is implemented in this revision; DDR is listed
  // so callers can name it and receive a clean elaboration error.
  localparam DATA_RATE_SDR = "SDR";
  localparam DATA_RATE_DDR = "DDR";

  // Deserializer control state.
  //   ST_RESET : first cycle after reset release
  //   ST_RUN   : sampling, counter advancing
  //   ST_HOLD  : EN low, everything frozen
  //   ST_SLIP  : the previous enabled cycle consumed a bitslip
  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_SLIP  = 2'd3
  } deser_state_t;

  // Bit-counter width for a given ratio; counts 0..w-1.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage : io_cells_pkg

// File: rtl/io_bitslip_ctrl.sv
// Bitslip request tracker: rising-edge detect on the slip level input and a
// sticky pending flag that the deserializer consumes.
// Latency: pending/busy rises the cycle after the 0->1 edge is sampled.
// Backpressure: requests arriving while one is pending are merged into it.
//
// Ports:
//   clk          bit clock, rising edge
//   rst          synchronous active-high reset
//   bitslip_adj  level input; each 0->1 transition requests one slip
//   consume      deserializer applies the pending slip this cycle
//   busy         slip request pending and not yet consumed
module io_bitslip_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic bitslip_adj,
  input  logic consume,
  output logic busy
);

  logic adj_q;
  logic pending_q;
  logic adj_rise;

  // Edge detect runs every cycle, independent of the sample enable.
  assign adj_rise = bitslip_adj & ~adj_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      adj_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      adj_q <= bitslip_adj;
      // A new edge wins over consumption so a request landing in the same
      // cycle as the slip it follows is kept rather than lost.
      if (adj_rise) begin
        pending_q <= 1'b1;
      end else if (consume) begin
        pending_q <= 1'b0;
      end
    end
  end

  assign busy = pending_q;

endmodule : io_bitslip_ctrl

// File: rtl/io_input_deserializer.sv
// Serial-to-parallel input stage behind the input buffer: assembles WIDTH-bit
// MSB-first words with bitslip alignment.
// Latency: Q/DATA_VALID update the cycle after the last bit of a word is sampled.
// Backpressure: none downstream; EN low freezes all datapath state.
//
// Ports:
//   CLK           bit clock, rising edge
//   RST           synchronous active-high reset
//   D             serial data from the input buffer
//   EN            sample enable
//   BITSLIP_ADJ   level input; each 0->1 edge delays the word boundary one bit
//   Q             deserialized word, Q[WIDTH-1] is the earliest bit
//   DATA_VALID    one-cycle strobe, Q updated this cycle
//   BITSLIP_BUSY  slip request pending
module io_input_deserializer
  import io_cells_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter     DATA_RATE = DATA_RATE_SDR
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             D,
  input  logic             EN,
  input  logic             BITSLIP_ADJ,
  output logic [WIDTH-1:0] Q,
  output logic             DATA_VALID,
  output logic             BITSLIP_BUSY
);

  // Elaboration-time parameter checks.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("io_input_deserializer: WIDTH=%0d outside %0d..%0d",
           WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (DATA_RATE != DATA_RATE_SDR) begin : g_bad_rate
    $error("io_input_deserializer: only SDR data rate is supported");
  end

  localparam int              CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Only the WIDTH-1 most recent samples are stored; the current D supplies
  // the final bit of a word directly, so a full WIDTH-bit register would
  // carry a bit that is never read.
  logic [WIDTH-2:0] shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] q_q;
  logic             dv_q;
  deser_state_t     state_q;

  logic             slip_pending;
  logic             slip_consume;
  logic [WIDTH-1:0] word_nxt;
  logic             cnt_at_last;

  io_bitslip_ctrl u_bitslip_ctrl (
    .clk         (CLK),
    .rst         (RST),
    .bitslip_adj (BITSLIP_ADJ),
    .consume     (slip_consume),
    .busy        (slip_pending)
  );

  // A pending slip is applied on the next enabled cycle only.
  assign slip_consume = EN & slip_pending;
  assign word_nxt     = {shift_q, D};
  assign cnt_at_last  = (cnt_q == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      dv_q    <= 1'b0;
      state_q <= ST_RESET;
    end else begin
      dv_q <= 1'b0;

      // Control state tracks what the datapath does this cycle.
      if (state_q == ST_RESET) begin
        state_q <= EN ? (slip_consume ? ST_SLIP : ST_RUN) : ST_RUN;
      end else if (slip_consume) begin
        state_q <= ST_SLIP;
      end else if (EN) begin
        state_q <= ST_RUN;
      end else begin
        state_q <= ST_HOLD;
      end

      if (EN) begin
        // The sample always enters the shift register, slip or not.
        shift_q <= word_nxt[WIDTH-2:0];
        if (slip_consume) begin
          // Counter holds: the extra sample pushes the boundary one bit
          // later, and a completion due this cycle is deferred.
          cnt_q <= cnt_q;
        end else if (cnt_at_last) begin
          cnt_q <= '0;
          q_q   <= word_nxt;
          dv_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign Q            = q_q;
  assign DATA_VALID   = dv_q;
  assign BITSLIP_BUSY = slip_pending;

endmodule : io_input_deserializer

// File: tb/tb_io_input_deserializer.sv
module tb_io_input_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       d = 1'b0;
  logic       en = 1'b0;
  logic       bitslip_adj = 1'b0;
  logic [3:0] q;
  logic       data_valid;
  logic       bitslip_busy;

  int n_cmp = 0;
  int n_err = 0;
  int pidx  = 0;

  io_input_deserializer #(.WIDTH(4), .DATA_RATE("SDR")) dut (
    .CLK          (clk),
    .RST          (rst),
    .D            (d),
    .EN           (en),
    .BITSLIP_ADJ  (bitslip_adj),
    .Q            (q),
    .DATA_VALID   (data_valid),
    .BITSLIP_BUSY (bitslip_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge, then settle so outputs can be sampled.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Next bit of the repeating 1,0,0,0 pattern.
  function automatic logic pat_bit();
    logic b;
    b = ((pidx % 4) == 0);
    pidx++;
    return b;
  endfunction

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; d = 1'b1; bitslip_adj = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (q !== 4'b0000) begin
      n_err++; $display("FAIL reset_q: got %b want %b", q, 4'b0000);
    end
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_dv: got %b want 0", data_valid);
    end
    n_cmp++;
    if (bitslip_busy !== 1'b0) begin
      n_err++; $display("FAIL reset_busy: got %b want 0", bitslip_busy);
    end
    rst = 1'b0; en = 1'b0; d = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] s;
    s = 8'b1011_0010;
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; d = s[7-i];
      tick();
      n_cmp++;
      if (data_valid !== (i == 3 || i == 7)) begin
        n_err++; $display("FAIL basic_dv[%0d]: got %b want %b", i, data_valid, (i == 3 || i == 7));
      end
      if (i == 3) begin
        n_cmp++;
        if (q !== 4'b1011) begin
          n_err++; $display("FAIL basic_q0: got %b want %b", q, 4'b1011);
        end
      end
      if (i == 7) begin
        n_cmp++;
        if (q !== 4'b0010) begin
          n_err++; $display("FAIL basic_q1: got %b want %b", q, 4'b0010);
        end
      end
    end
  endtask

  task automatic test_bitslip;
    logic [3:0] exp_w [4];
    exp_w[0] = 4'b0001; exp_w[1] = 4'b0010; exp_w[2] = 4'b0100; exp_w[3] = 4'b1000;
    // Two aligned words first.
    for (int i = 0; i < 8; i++) begin
      en = 1'b1; d = pat_bit();
      tick();
      if (i == 3 || i == 7) begin
        n_cmp++;
        if (data_valid !== 1'b1 || q !== 4'b1000) begin
          n_err++; $display("FAIL steady_word[%0d]: got dv=%b q=%b want dv=1 q=1000", i, data_valid, q);
        end
      end
    end
    // Four single slips, each rotating the captured word by one bit.
    for (int k = 0; k < 4; k++) begin
      en = 1'b1; d = pat_bit(); bitslip_adj = 1'b1;
      tick();
      n_cmp++;
      if (bitslip_busy !== 1'b1) begin
        n_err++; $display("FAIL slip_busy_set[%0d]: got %b want 1", k, bitslip_busy);
      end
      bitslip_adj = 1'b0;
      for (int e = 2; e <= 5; e++) begin
        d = pat_bit();
        tick();
        if (e == 2) begin
          n_cmp++;
          if (bitslip_busy !== 1'b0) begin
            n_err++; $display("FAIL slip_busy_clr[%0d]: got %b want 0", k, bitslip_busy);
          end
        end
        n_cmp++;
        if (data_valid !== (e == 5)) begin
          n_err++; $display("FAIL slip_dv[%0d.%0d]: got %b want %b", k, e, data_valid, (e == 5));
        end
        if (e == 5) begin
          n_cmp++;
          if (q !== exp_w[k]) begin
            n_err++; $display("FAIL slip_q[%0d]: got %b want %b", k, q, exp_w[k]);
          end
        end
      end
    end
  endtask

  task automatic test_en_hold;
    en = 1'b1; d = 1'b1; tick();
    en = 1'b1; d = 1'b1; tick();
    en = 1'b0; d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (data_valid !== 1'b0 || q !== 4'b1000) begin
        n_err++; $display("FAIL hold[%0d]: got dv=%b q=%b want dv=0 q=1000", i, data_valid, q);
      end
    end
    en = 1'b1; d = 1'b0; tick();
    n_cmp++;
    if (data_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_resume_dv: got %b want 0", data_valid);
    end
    d = 1'b1; tick();
    n_cmp++;
    if (data_valid !== 1'b1 || q !== 4'b1101) begin
      n_err++; $display("FAIL hold_word: got dv=%b q=%b want dv=1 q=1101", data_valid, q);
    end
  endtask

  task automatic test_slip_while_disabled;
    logic [4:0] s;
    s = 5'b10101;
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bitslip_adj = (i == 0 || i == 2);
      tick();
      n_cmp++;
      if (bitslip_busy !== 1'b1) begin
        n_err++; $display("FAIL dis_busy[%0d]: got %b want 1", i, bitslip_busy);
      end
    end
    bitslip_adj = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; d = s[4-i];
      tick();
      if (i == 0) begin
        n_cmp++;
        if (bitslip_busy !== 1'b0) begin
          n_err++; $display("FAIL dis_consume: got %b want 0", bitslip_busy);
        end
      end
      n_cmp++;
      if (data_valid !== (i == 4)) begin
        n_err++; $display("FAIL dis_dv[%0d]: got %b want %b", i, data_valid, (i == 4));
      end
      if (i == 4) begin
        n_cmp++;
        if (q !== 4'b0101) begin
          n_err++; $display("FAIL dis_q: got %b want %b", q, 4'b0101);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0] s;
    s = 4'b0110;
    en = 1'b1; d = 1'b1; tick();
    d = 1'b1; tick();
    rst = 1'b1; d = 1'b1; bitslip_adj = 1'b1;
    tick();
    n_cmp++;
    if (q !== 4'b0000 || data_valid !== 1'b0 || bitslip_busy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got q=%b dv=%b busy=%b want q=0000 dv=0 busy=0", q, data_valid, bitslip_busy);
    end
    rst = 1'b0; bitslip_adj = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = s[3-i];
      tick();
      n_cmp++;
      if (data_valid !== (i == 3)) begin
        n_err++; $display("FAIL post_reset_dv[%0d]: got %b want %b", i, data_valid, (i == 3));
      end
    end
    n_cmp++;
    if (q !== 4'b0110) begin
      n_err++; $display("FAIL post_reset_q: got %b want %b", q, 4'b0110);
    end
  endtask

  task automatic test_slip_on_last;
    logic [8:0] s;
    int since;
    int exp_gap;
    s = 9'b11001_0111;
    since = 0;
    exp_gap = 5;
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      d = s[8-i];
      bitslip_adj = (i == 2);
      tick();
      since++;
      if (i == 2) begin
        n_cmp++;
        if (bitslip_busy !== 1'b1) begin
          n_err++; $display("FAIL last_busy: got %b want 1", bitslip_busy);
        end
      end
      n_cmp++;
      if (data_valid !== (i == 4 || i == 8)) begin
        n_err++; $display("FAIL last_dv[%0d]: got %b want %b", i, data_valid, (i == 4 || i == 8));
      end
      if (data_valid === 1'b1) begin
        n_cmp++;
        if (since !== exp_gap) begin
          n_err++; $display("FAIL last_gap: got %0d want %0d", since, exp_gap);
        end
        since = 0;
        exp_gap = 4;
      end
      if (i == 4) begin
        n_cmp++;
        if (q !== 4'b1001) begin
          n_err++; $display("FAIL last_q0: got %b want %b", q, 4'b1001);
        end
      end
      if (i == 8) begin
        n_cmp++;
        if (q !== 4'b0111) begin
          n_err++; $display("FAIL last_q1: got %b want %b", q, 4'b0111);
        end
      end
    end
    bitslip_adj = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bitslip();
    test_en_hold();
    test_slip_while_disabled();
    test_reset_mid();
    test_slip_on_last();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_io_input_deserializer
